cpu_req_sequencer: RTL

- Parametrised, programmable CPU-side request generator for cache/memory hierarchy testbenches; successor to the fixed-table, reset-less request stub.
- Holds a loadable table of read/write requests and issues them one at a time to the cache with a valid/hit handshake.
- Checks read data against expected values and reports error count, first failing index and completion.

---
 rtl/cpu_seq_pkg.sv | 30 +++
 rtl/cpu_req_sequencer_table.sv | 29 ++
 rtl/cpu_req_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types for the CPU request sequencer: controller states, the
// default-width request table entry and the error counter width.
package cpu_seq_pkg;

   // Controller states: IDLE after reset, RUN while issuing, DONE until next start.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   localparam int ERR_W      = 8;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   // One table entry at the default widths. The top module builds the same
   // field layout at its own parameterised widths.
   typedef struct packed {
      logic                  rw;
      logic                  chk;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } req_entry_t;

   // Saturating increment for the mismatch counter.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

endpackage

// File: rtl/cpu_req_sequencer_table.sv
// Request table: DEPTH entries, synchronous write, combinational read by
// index. Contents are deliberately not reset so a reset keeps the program.
module req_table
   import cpu_seq_pkg::*;
#(
   parameter int  DEPTH   = 32,
   parameter int  IDX_W   = $clog2(DEPTH),
   parameter type entry_t = req_entry_t
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  entry_t           wr_entry_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output entry_t           rd_entry_o
);

   entry_t mem_q [DEPTH];

   // Write port: one entry per cycle when enabled.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_idx_i] <= wr_entry_i;
      end
   end

   assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/cpu_req_sequencer.sv
// CPU-side request sequencer: replays a programmed table of reads/writes to a
// cache one request at a time, checks read data and reports errors.
// Optional watchdog: define REQ_TIMEOUT_EN to abort a request that waits
// TIMEOUT cycles without a hit.
module cpu_req_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 32,
   parameter int IDX_W   = $clog2(DEPTH),
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [IDX_W:0]    num_req,
   input  logic              prog_we,
   input  logic [IDX_W-1:0]  prog_idx,
   input  logic              prog_rw,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_chk,
   output logic              req_valid,
   output logic              req_rw,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              resp_hit,
   input  logic [DATA_W-1:0] resp_rdata,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  req_idx,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic              timeout
);

   // Handshake: a request completes on a rising edge where req_valid and
   // resp_hit are both high; resp_rdata is only meaningful in that cycle.
   // The request outputs hold steady until that edge.

   typedef struct packed {
      logic              rw;
      logic              chk;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   if (TIMEOUT < 1 || DEPTH < 2) begin : g_param_check
      $error("cpu_req_sequencer: TIMEOUT must be >= 1 and DEPTH >= 2");
   end

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W:0]   num_q, num_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [IDX_W-1:0] ferr_q, ferr_d;
   logic             to_q, to_d;

   entry_t wr_entry;
   entry_t cur;
   logic   tbl_we;
   logic   running;
   logic   hit;
   logic   last;
   logic   mismatch;
   logic   expire;

   // The table is frozen while a run is in progress.
   assign running  = (state_q == RUN);
   assign tbl_we   = prog_we && !running;
   assign wr_entry = '{rw: prog_rw, chk: prog_chk, addr: prog_addr, data: prog_data};

   req_table #(
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W),
      .entry_t (entry_t)
   ) u_table (
      .clk_i      (clk),
      .we_i       (tbl_we),
      .wr_idx_i   (prog_idx),
      .wr_entry_i (wr_entry),
      .rd_idx_i   (idx_q),
      .rd_entry_o (cur)
   );

   assign hit      = running && resp_hit;
   assign last     = ({1'b0, idx_q} == (num_q - (IDX_W+1)'(1)));
   assign mismatch = hit && !cur.rw && cur.chk && (resp_rdata != cur.data);

`ifdef REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Wait counter restarts on every issue and every hit.
   always_comb begin
      wait_d = '0;
      if (running && !resp_hit) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign expire = running && !resp_hit && (wait_q == WAIT_W'(TIMEOUT - 1));
`else
   assign expire = 1'b0;
`endif

   // Next-state logic: start handling, completion, error capture, watchdog.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      num_d   = num_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      to_d    = to_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               num_d   = num_req;
               idx_d   = '0;
               err_d   = '0;
               ferr_d  = '0;
               to_d    = 1'b0;
               state_d = (num_req == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (hit) begin
               if (mismatch) begin
                  err_d = sat_inc(err_q);
                  // err_q only grows within a run, so zero means no earlier mismatch.
                  if (err_q == '0) begin
                     ferr_d = idx_q;
                  end
               end
               if (last) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (expire) begin
               state_d = DONE;
               to_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         num_q   <= '0;
         err_q   <= '0;
         ferr_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         to_q    <= to_d;
      end
   end

   // Request fields are gated so every output is zero outside a run.
   assign busy          = running;
   assign req_valid     = running;
   assign req_rw        = running && cur.rw;
   assign req_addr      = running ? cur.addr : '0;
   assign req_wdata     = running ? cur.data : '0;
   assign done          = (state_q == DONE);
   assign req_idx       = idx_q;
   assign err_cnt       = err_q;
   assign first_err_idx = ferr_q;
   assign timeout       = to_q;

endmodule
